ysyx_23060201_mem_arbiter: RTL and testbench

Two-master arbiter and sequencer for the single shared physical-memory port. It sits between the IFU (instruction fetch, read-only) and the LSU (loads and stores) on one side, and the memory access unit (DPI `pmem_read`/`pmem_write` wrapper) on the other. It accepts one request at a time and drives it onto the memory port with valid/ready handshakes. It routes the response back to the owning master, with round-robin fairness and a response timeout.

---
 rtl/ysyx_23060201_mem_arbiter_if.sv | 54 +++++
 rtl/ysyx_23060201_mem_arbiter.sv | 132 +++++++++++++
 tb/tb_ysyx_23060201_mem_arbiter.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060201_mem_arbiter_if.sv
// Bus bundle between the IFU/LSU masters, the arbiter and the memory access unit.
// The slave modport is the arbiter's view; master is the environment's view.
interface ysyx_23060201_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ifu_req_valid;
  logic                  ifu_req_ready;
  logic [ADDR_WIDTH-1:0] ifu_req_addr;
  logic                  ifu_resp_valid;
  logic                  ifu_resp_ready;
  logic [DATA_WIDTH-1:0] ifu_resp_rdata;
  logic                  ifu_resp_err;

  logic                  lsu_req_valid;
  logic                  lsu_req_ready;
  logic [ADDR_WIDTH-1:0] lsu_req_addr;
  logic                  lsu_req_wen;
  logic [DATA_WIDTH-1:0] lsu_req_wdata;
  logic [7:0]            lsu_req_wmask;
  logic                  lsu_resp_valid;
  logic                  lsu_resp_ready;
  logic [DATA_WIDTH-1:0] lsu_resp_rdata;
  logic                  lsu_resp_err;

  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [7:0]            mem_wmask;
  logic                  mem_resp_valid;
  logic [DATA_WIDTH-1:0] mem_resp_rdata;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Round-robin IFU/LSU arbiter for the single physical-memory port: one transaction
// in flight, registered memory request, response routed to the owner, timeout error.
module ysyx_23060201_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic clk,
  input  logic rst,
  ysyx_23060201_mem_arbiter_if.slave bus,
  output logic busy,
  output logic owner_lsu
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic                  lsu;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [7:0]            wmask;
  } req_t;

  logic [1:0]            r_state;
  req_t                  r_req;
  logic                  r_last_lsu;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;

  logic w_idle;
  logic w_any;
  logic w_grant_lsu;
  logic w_timeout;
  logic w_owner_ack;
  req_t w_new;

  // Tie-break toward whichever master did not win last time.
  assign w_any       = bus.ifu_req_valid | bus.lsu_req_valid;
  assign w_grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | ~r_last_lsu);
  assign w_idle      = (r_state == S_IDLE) & ~rst;
  assign w_timeout   = ((r_state == S_ISSUE) | (r_state == S_WAIT)) & (r_cnt == CNT_LAST);
  assign w_owner_ack = r_req.lsu ? bus.lsu_resp_ready : bus.ifu_resp_ready;

  always_comb begin
    w_new = '0;
    if (w_grant_lsu) begin
      w_new.lsu   = 1'b1;
      w_new.addr  = bus.lsu_req_addr;
      w_new.wen   = bus.lsu_req_wen;
      w_new.wdata = bus.lsu_req_wdata;
      w_new.wmask = bus.lsu_req_wen ? bus.lsu_req_wmask : 8'h00;
    end else begin
      w_new.addr  = bus.ifu_req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_req      <= '0;
      r_last_lsu <= 1'b1;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_req      <= w_new;
            r_last_lsu <= w_grant_lsu;
            r_cnt      <= '0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end else if (bus.mem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // A completion in the final cycle still beats the timeout.
          if (bus.mem_resp_valid) begin
            r_rdata <= r_req.wen ? '0 : bus.mem_resp_rdata;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        default: begin
          if (w_owner_ack) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ifu_req_ready  = w_idle & bus.ifu_req_valid & ~w_grant_lsu;
  assign bus.lsu_req_ready  = w_idle & w_grant_lsu;

  assign bus.mem_req_valid  = (r_state == S_ISSUE);
  assign bus.mem_addr       = r_req.addr;
  assign bus.mem_wen        = r_req.wen;
  assign bus.mem_wdata      = r_req.wdata;
  assign bus.mem_wmask      = r_req.wmask;

  assign bus.ifu_resp_valid = (r_state == S_RESP) & ~r_req.lsu;
  assign bus.lsu_resp_valid = (r_state == S_RESP) &  r_req.lsu;
  assign bus.ifu_resp_rdata = r_rdata;
  assign bus.lsu_resp_rdata = r_rdata;
  assign bus.ifu_resp_err   = r_err;
  assign bus.lsu_resp_err   = r_err;

  assign busy      = (r_state != S_IDLE);
  assign owner_lsu = r_req.lsu;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter (TIMEOUT = 8).
module tb_ysyx_23060201_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy, owner_lsu;
  int   total = 0;
  int   passes = 0;

  ysyx_23060201_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_23060201_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .owner_lsu(owner_lsu)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    bus.ifu_req_valid = 0; bus.ifu_req_addr = '0; bus.ifu_resp_ready = 0;
    bus.lsu_req_valid = 0; bus.lsu_req_addr = '0; bus.lsu_req_wen = 0;
    bus.lsu_req_wdata = '0; bus.lsu_req_wmask = '0; bus.lsu_resp_ready = 0;
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_rdata = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    smp();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner_lsu, 0);
    chk("rst_ifu_rdy", bus.ifu_req_ready, 0);
    chk("rst_lsu_rdy", bus.lsu_req_ready, 0);
    chk("rst_mem_vld", bus.mem_req_valid, 0);
    chk("rst_resp_vld", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    tick();

    // single IFU read, best case
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0000;
    bus.mem_req_ready = 1; bus.ifu_resp_ready = 1;
    smp();
    chk("t1_ifu_rdy", bus.ifu_req_ready, 1);
    chk("t1_lsu_rdy", bus.lsu_req_ready, 0);
    tick();
    bus.ifu_req_valid = 0;
    smp();
    chk("t1_mem_vld", bus.mem_req_valid, 1);
    chk("t1_mem_addr", bus.mem_addr, 32'h8000_0000);
    chk("t1_mem_wen", bus.mem_wen, 0);
    chk("t1_mem_wmask", bus.mem_wmask, 0);
    chk("t1_busy", busy, 1);
    tick();
    bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'hDEAD_BEEF;
    smp();
    chk("t1_mem_vld_drop", bus.mem_req_valid, 0);
    tick();
    bus.mem_resp_valid = 0;
    smp();
    chk("t1_resp_vld", bus.ifu_resp_valid, 1);
    chk("t1_rdata", bus.ifu_resp_rdata, 32'hDEAD_BEEF);
    chk("t1_err", bus.ifu_resp_err, 0);
    chk("t1_lsu_vld", bus.lsu_resp_valid, 0);
    tick();
    smp();
    chk("t1_idle", busy, 0);
    chk("t1_resp_gone", bus.ifu_resp_valid, 0);
    tick();

    // LSU write with mem_req_ready held low 3 cycles
    bus.mem_req_ready = 0; bus.lsu_resp_ready = 1;
    bus.lsu_req_valid = 1; bus.lsu_req_wen = 1; bus.lsu_req_addr = 32'h8000_0004;
    bus.lsu_req_wdata = 32'h1234_5678; bus.lsu_req_wmask = 8'h0F;
    smp();
    chk("t2_lsu_rdy", bus.lsu_req_ready, 1);
    tick();
    bus.lsu_req_valid = 0; bus.lsu_req_wen = 0; bus.lsu_req_wmask = 0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("t2_hold_vld", bus.mem_req_valid, 1);
      chk("t2_hold_wen", bus.mem_wen, 1);
      chk("t2_hold_wmask", bus.mem_wmask, 8'h0F);
      chk("t2_hold_wdata", bus.mem_wdata, 32'h1234_5678);
      chk("t2_hold_addr", bus.mem_addr, 32'h8000_0004);
      tick();
    end
    bus.mem_req_ready = 1;
    smp();
    chk("t2_issue_vld", bus.mem_req_valid, 1);
    tick();
    bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'hAAAA_5555;
    tick();
    bus.mem_resp_valid = 0;
    smp();
    chk("t2_resp_vld", bus.lsu_resp_valid, 1);
    chk("t2_ifu_vld", bus.ifu_resp_valid, 0);
    chk("t2_rdata_zero", bus.lsu_resp_rdata, 0);
    chk("t2_owner", owner_lsu, 1);
    tick();
    smp();
    chk("t2_idle", busy, 0);
    tick();

    // round robin from reset with both masters always valid
    rst = 1; tick(); rst = 0;
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h0000_1000;
    bus.lsu_req_valid = 1; bus.lsu_req_addr = 32'h0000_2000; bus.lsu_req_wen = 0;
    bus.ifu_resp_ready = 1; bus.lsu_resp_ready = 1;
    for (int i = 0; i < 6; i++) begin
      smp();
      chk("rr_ifu_grant", bus.ifu_req_ready, (i % 2 == 0));
      chk("rr_lsu_grant", bus.lsu_req_ready, (i % 2 == 1));
      tick();
      smp();
      chk("rr_mem_addr", bus.mem_addr, (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      tick();
      bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'h100 + i;
      tick();
      bus.mem_resp_valid = 0;
      smp();
      chk("rr_ifu_resp", bus.ifu_resp_valid, (i % 2 == 0));
      chk("rr_lsu_resp", bus.lsu_resp_valid, (i % 2 == 1));
      chk("rr_rdata", (i % 2 == 0) ? bus.ifu_resp_rdata : bus.lsu_resp_rdata, 32'h100 + i);
      tick();
    end
    bus.ifu_req_valid = 0; bus.lsu_req_valid = 0;

    // timeout: memory accepts but never responds
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0100;
    smp();
    chk("to_grant", bus.ifu_req_ready, 1);
    tick();
    bus.ifu_req_valid = 0;
    for (int k = 0; k < 8; k++) begin
      smp();
      chk("to_busy", busy, 1);
      chk("to_no_resp", bus.ifu_resp_valid, 0);
      chk("to_mem_vld", bus.mem_req_valid, (k == 0));
      tick();
    end
    smp();
    chk("to_resp_vld", bus.ifu_resp_valid, 1);
    chk("to_err", bus.ifu_resp_err, 1);
    chk("to_rdata", bus.ifu_resp_rdata, 0);
    chk("to_mem_vld_off", bus.mem_req_valid, 0);
    tick();
    smp();
    chk("to_idle", busy, 0);
    tick();

    // LSU response backpressure with IFU waiting (last grant was IFU)
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0200;
    bus.lsu_req_valid = 1; bus.lsu_req_addr = 32'h0000_3000; bus.lsu_req_wen = 0;
    bus.lsu_resp_ready = 0;
    smp();
    chk("bp_lsu_grant", bus.lsu_req_ready, 1);
    chk("bp_ifu_wait", bus.ifu_req_ready, 0);
    tick();
    bus.lsu_req_valid = 0;
    tick();
    bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'hCAFE_F00D;
    tick();
    bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("bp_vld", bus.lsu_resp_valid, 1);
      chk("bp_rdata", bus.lsu_resp_rdata, 32'hCAFE_F00D);
      chk("bp_ifu_rdy", bus.ifu_req_ready, 0);
      tick();
    end
    bus.mem_resp_valid = 0;
    bus.lsu_resp_ready = 1;
    smp();
    chk("bp_ack_vld", bus.lsu_resp_valid, 1);
    chk("bp_ack_ifu_rdy", bus.ifu_req_ready, 0);
    tick();
    smp();
    chk("bp_ifu_grant", bus.ifu_req_ready, 1);
    tick();

    // reset during WAIT aborts the IFU transaction
    bus.ifu_req_valid = 0;
    tick();
    rst = 1;
    smp();
    chk("rw_busy_before", busy, 1);
    tick();
    rst = 0;
    smp();
    chk("rw_busy", busy, 0);
    chk("rw_mem_vld", bus.mem_req_valid, 0);
    chk("rw_resp_vld", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 0);
    chk("rw_owner", owner_lsu, 0);
    tick();
    bus.ifu_req_valid = 1; bus.ifu_req_addr = 32'h8000_0300;
    smp();
    chk("rw_grant", bus.ifu_req_ready, 1);
    tick();
    bus.ifu_req_valid = 0;
    smp();
    chk("rw_mem_addr", bus.mem_addr, 32'h8000_0300);
    tick();
    bus.mem_resp_valid = 1; bus.mem_resp_rdata = 32'h600D_CAFE;
    tick();
    bus.mem_resp_valid = 0;
    smp();
    chk("rw_resp_vld2", bus.ifu_resp_valid, 1);
    chk("rw_rdata", bus.ifu_resp_rdata, 32'h600D_CAFE);
    chk("rw_err", bus.ifu_resp_err, 0);
    tick();
    smp();
    chk("rw_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
